// File: rtl/mult_share_pkg.sv
// Shared types, default parameters and round-robin selection for mult_share_sched.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH         = 2;
  localparam int DEF_N_REQ         = 4;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int DEF_IDW           = 2;
  localparam int MAX_REQ           = 32;

  // Lowest offset from ptr with a set valid bit wins; returns 0 when nothing is valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    rr_pick = 32'd0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (32'(k) < n) begin
        idx = (ptr + 32'(k)) % n;
        if (valid[idx]) begin
          rr_pick = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned multiplier; stands in for the candidate netlist under evaluation.
module multiplier #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P
);

  assign P = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one combinational multiplier among N_REQ
// requesters, with a settle window before the product is sampled.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int N_REQ         = DEF_N_REQ,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int IDW           = DEF_IDW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]     rsp_p,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     id;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;
  logic [MAX_REQ-1:0] valid_ext;
  logic [IDW-1:0]     grant;
  logic               any_valid;

  multiplier #(.WIDTH(WIDTH)) u_mult (
    .A (op_a),
    .B (op_b),
    .P (prod)
  );

  // Widen the valid mask to the fixed width the pick function expects.
  always_comb begin
    valid_ext = '0;
    valid_ext[N_REQ-1:0] = req_valid;
  end

  assign any_valid = |req_valid;
  assign grant     = IDW'(rr_pick(valid_ext, 32'(ptr), N_REQ));

  // Accept strobe is only offered while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) begin
      req_ready[grant] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Control FSM with registered response, busy flag and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      busy      <= 1'b0;
      op_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a  <= req_a[grant*WIDTH +: WIDTH];
            op_b  <= req_b[grant*WIDTH +: WIDTH];
            id    <= grant;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            rsp_p     <= prod;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= op_count + 16'd1;
            ptr       <= (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (WIDTH=2, N_REQ=4, SETTLE_CYCLES=1).
module tb_mult_share_sched;

  localparam int WIDTH = 2;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [2*WIDTH-1:0]     rsp_p;
  logic                   busy;
  logic [15:0]            op_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int exp_gnt[4];
  int exp_prd[4];

  always #5 clk = ~clk;

  mult_share_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .SETTLE_CYCLES(1), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [1:0] a, input logic [1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Runs held-ready traffic until n grants and n responses are seen.
  task automatic run_traffic(input int n, input bit clear_on_grant);
    int ng = 0;
    int nr = 0;
    int cyc = 0;
    int last = -1;
    int g;
    bit granted;
    while ((ng < n || nr < n) && cyc < 40) begin
      granted = 1'b0;
      g = 0;
      if (rsp_valid && nr < n) begin
        check("rsp_id", 32'(rsp_id), 32'(exp_gnt[nr]));
        check("rsp_p", 32'(rsp_p), 32'(exp_prd[rsp_id]));
        nr++;
        exp_count++;
      end
      if (|req_ready) begin
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (ng < n) check("grant", 32'(g), 32'(exp_gnt[ng]));
        if (last >= 0) check("spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        ng++;
        granted = 1'b1;
      end
      step();
      cyc++;
      if (granted) begin
        if (clear_on_grant) req_valid[g] = 1'b0;
        if (ng == n) req_valid = '0;
      end
    end
    check("traffic_done", 32'(ng == n && nr == n), 32'd1);
    check("traffic_count", 32'(op_count), 32'(exp_count));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_p", 32'(rsp_p), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    step();

    // single request
    set_op(0, 2'd3, 2'd1);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check("t1_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_novalid", 32'(rsp_valid), 32'd0);
    step();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_p", 32'(rsp_p), 32'd3);
    check("t1_id", 32'(rsp_id), 32'd0);
    step();
    check("t1_done", 32'(rsp_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_count", 32'(op_count), 32'd1);

    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_count = 0;
    check("rst2_count", 32'(op_count), 32'd0);
    step();

    // four requesters in round-robin order
    set_op(0, 2'd3, 2'd1);
    set_op(1, 2'd2, 2'd3);
    set_op(2, 2'd2, 2'd2);
    set_op(3, 2'd3, 2'd3);
    exp_gnt = '{0, 1, 2, 3};
    exp_prd = '{3, 6, 4, 9};
    req_valid = 4'b1111;
    #1;
    run_traffic(4, 1'b1);

    // fairness between 1 and 3 with pointer wrap
    set_op(1, 2'd1, 2'd1);
    set_op(3, 2'd3, 2'd2);
    exp_gnt = '{1, 3, 1, 3};
    exp_prd = '{0, 1, 0, 6};
    req_valid = 4'b1010;
    #1;
    run_traffic(4, 1'b0);

    // backpressure
    rsp_ready = 1'b0;
    set_op(2, 2'd2, 2'd2);
    req_valid = 4'b0100;
    #1;
    check("bp_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    set_op(3, 2'd3, 2'd3);
    req_valid = 4'b1000;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_p", 32'(rsp_p), 32'd4);
      check("bp_id", 32'(rsp_id), 32'd2);
      check("bp_noready", 32'(req_ready), 32'd0);
      check("bp_count", 32'(op_count), 32'(exp_count));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_noready", 32'(req_ready), 32'd0);
    step();
    exp_count++;
    check("bp_hs_valid", 32'(rsp_valid), 32'd0);
    check("bp_hs_busy", 32'(busy), 32'd0);
    check("bp_hs_count", 32'(op_count), 32'(exp_count));
    check("bp_next_ready", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    step();
    check("bp2_p", 32'(rsp_p), 32'd9);
    check("bp2_id", 32'(rsp_id), 32'd3);
    step();
    exp_count++;
    check("bp2_count", 32'(op_count), 32'(exp_count));

    // reset in the middle of SETTLE
    set_op(0, 2'd3, 2'd3);
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    check("mr_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_count = 0;
    check("mr_valid", 32'(rsp_valid), 32'd0);
    check("mr_busy0", 32'(busy), 32'd0);
    check("mr_count", 32'(op_count), 32'd0);
    check("mr_p", 32'(rsp_p), 32'd0);
    check("mr_id", 32'(rsp_id), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mr_silent", 32'(rsp_valid), 32'd0);
      step();
    end
    set_op(0, 2'd1, 2'd2);
    set_op(3, 2'd3, 2'd3);
    req_valid = 4'b1001;
    #1;
    check("mr_ptr0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    check("mr_p2", 32'(rsp_p), 32'd2);
    check("mr_id2", 32'(rsp_id), 32'd0);
    step();
    check("mr_count2", 32'(op_count), 32'd1);

    // op_count wrap
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    #1;
    check("wr_preset", 32'(op_count), 32'hFFFF);
    set_op(1, 2'd1, 2'd3);
    req_valid = 4'b0010;
    #1;
    check("wr_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    check("wr_p", 32'(rsp_p), 32'd3);
    step();
    check("wr_count", 32'(op_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
